// File: rtl/stepped_range_counter.sv
// Range counter that steps from a latched start value to a latched end value, either
// stopping at the end or wrapping back to the start, with sticky configuration-error reporting.
module stepped_range_counter #(
    parameter int Bits     = 8,
    parameter int StepBits = 4
) (
    input  logic                clk_i,
    input  logic                arst_ni,
    input  logic                clear_i,
    input  logic                start_i,
    input  logic                en_i,
    input  logic                mode_i,
    input  logic [Bits-1:0]     start_val_i,
    input  logic [Bits-1:0]     end_val_i,
    input  logic [StepBits-1:0] step_i,
    output logic [Bits-1:0]     count_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                wrap_o,
    output logic                cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [Bits-1:0]     count_q, count_d;
    logic                wrap_q, wrap_d;
    logic                cfg_err_q, cfg_err_d;
    logic [Bits-1:0]     start_q, start_d;
    logic [Bits-1:0]     end_q, end_d;
    logic [StepBits-1:0] step_q, step_d;
    logic                mode_q, mode_d;

    logic [Bits-1:0]     step_eff;
    logic [Bits-1:0]     remain;

    // A latched step of zero would stall the counter forever, so it advances by one instead.
    assign step_eff = (step_q == '0) ? Bits'(1) : Bits'(step_q);
    assign remain   = end_q - count_q;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wrap_d    = 1'b0;
        cfg_err_d = cfg_err_q;
        start_d   = start_q;
        end_d     = end_q;
        step_d    = step_q;
        mode_d    = mode_q;

        if (clear_i) begin
            state_d   = IDLE;
            count_d   = '0;
            cfg_err_d = 1'b0;
        end else if (start_i) begin
            if (end_val_i >= start_val_i) begin
                start_d = start_val_i;
                end_d   = end_val_i;
                step_d  = step_i;
                mode_d  = mode_i;
                count_d = start_val_i;
                // An empty range in stop mode has nothing to count.
                if ((end_val_i == start_val_i) && !mode_i) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end else begin
                cfg_err_d = 1'b1;
                state_d   = IDLE;
            end
        end else if ((state_q == RUN) && en_i) begin
            if (count_q < end_q) begin
                // Clamp to the end value; the sum is never formed when it could overflow.
                if (step_eff < remain) begin
                    count_d = count_q + step_eff;
                end else begin
                    count_d = end_q;
                    if (!mode_q) begin
                        state_d = DONE;
                    end
                end
            end else if (mode_q) begin
                count_d = start_q;
                wrap_d  = 1'b1;
            end else begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= IDLE;
            count_q   <= '0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            start_q   <= '0;
            end_q     <= '0;
            step_q    <= '0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
            start_q   <= start_d;
            end_q     <= end_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
        end
    end

    assign count_o   = count_q;
    assign busy_o    = (state_q == RUN);
    assign done_o    = (state_q == DONE);
    assign wrap_o    = wrap_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_stepped_range_counter.sv
// Bench for stepped_range_counter: directed scenarios plus randomized traffic
// compared cycle by cycle against an arithmetic reference model.
module tb_stepped_range_counter;

    localparam int Bits     = 8;
    localparam int StepBits = 4;

    logic                clk_i = 1'b0;
    logic                arst_ni;
    logic                clear_i, start_i, en_i, mode_i;
    logic [Bits-1:0]     start_val_i, end_val_i;
    logic [StepBits-1:0] step_i;
    logic [Bits-1:0]     count_o;
    logic                busy_o, done_o, wrap_o, cfg_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: 0 = idle, 1 = run, 2 = done.
    int m_state, m_count, m_wrap, m_err, m_start, m_end, m_step, m_mode;

    stepped_range_counter #(.Bits(Bits), .StepBits(StepBits)) dut (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .en_i       (en_i),
        .mode_i     (mode_i),
        .start_val_i(start_val_i),
        .end_val_i  (end_val_i),
        .step_i     (step_i),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .wrap_o     (wrap_o),
        .cfg_err_o  (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_wrap = 0; m_err = 0;
        m_start = 0; m_end = 0; m_step = 0; m_mode = 0;
    endtask

    // Next-cycle behaviour from the rules: count moves toward the end by min(step, distance).
    task automatic model_apply();
        int st;
        m_wrap = 0;
        if (clear_i) begin
            m_state = 0; m_count = 0; m_err = 0;
        end else if (start_i) begin
            if (int'(end_val_i) >= int'(start_val_i)) begin
                m_start = start_val_i; m_end = end_val_i;
                m_step = step_i; m_mode = mode_i;
                m_count = start_val_i;
                m_state = (m_start == m_end && m_mode == 0) ? 2 : 1;
            end else begin
                m_err = 1; m_state = 0;
            end
        end else if (m_state == 1 && en_i) begin
            st = (m_step == 0) ? 1 : m_step;
            if (m_count < m_end) begin
                m_count = (m_count + st > m_end) ? m_end : m_count + st;
                if (m_count == m_end && m_mode == 0) m_state = 2;
            end else begin
                m_count = m_start; m_wrap = 1;
            end
        end
    endtask

    task automatic cycle();
        model_apply();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i = 0; start_i = 0; en_i = 0; mode_i = 0;
        start_val_i = '0; end_val_i = '0; step_i = '0;
    endtask

    task automatic do_start(input int s, input int e, input int st, input logic md);
        start_i = 1; start_val_i = Bits'(s); end_val_i = Bits'(e);
        step_i = StepBits'(st); mode_i = md;
        cycle();
        start_i = 0;
        // Scramble config inputs: only the latched copy may matter from here on.
        start_val_i = Bits'($urandom); end_val_i = Bits'($urandom);
        step_i = StepBits'($urandom); mode_i = 1'($urandom);
    endtask

    task automatic test_reset();
        idle_inputs();
        arst_ni = 0;
        model_reset();
        #12;
        n_tests++;
        if ({count_o, busy_o, done_o, wrap_o, cfg_err_o} !== {8'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset: count=%0d busy=%b done=%b wrap=%b err=%b, need all 0",
                     count_o, busy_o, done_o, wrap_o, cfg_err_o);
        end
        arst_ni = 1;
        en_i = 1;
        cycle();
        n_tests++;
        if (count_o !== 8'd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_en: count=%0d busy=%b, need 0 0", count_o, busy_o);
        end
    endtask

    task automatic test_stop_seq();
        int exp_c[4] = '{3, 6, 9, 10};
        idle_inputs();
        en_i = 1;
        do_start(3, 10, 3, 0);
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (count_o !== Bits'(exp_c[i]) || busy_o !== (i < 3) || done_o !== (i == 3)) begin
                n_fail++;
                $display("FAIL stop_seq[%0d]: count=%0d busy=%b done=%b, need %0d %b %b",
                         i, count_o, busy_o, done_o, exp_c[i], i < 3, i == 3);
            end
            if (i < 3) cycle();
        end
        cycle(); cycle();
        n_tests++;
        if (count_o !== 8'd10 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_hold: count=%0d done=%b, need 10 1", count_o, done_o);
        end
    endtask

    task automatic test_wrap();
        int exp_c[5] = '{250, 254, 255, 250, 254};
        int exp_w[5] = '{0, 0, 0, 1, 0};
        idle_inputs();
        en_i = 1;
        do_start(250, 255, 4, 1);
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (count_o !== Bits'(exp_c[i]) || wrap_o !== 1'(exp_w[i]) || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_seq[%0d]: count=%0d wrap=%b busy=%b, need %0d %0d 1",
                         i, count_o, wrap_o, busy_o, exp_c[i], exp_w[i]);
            end
            if (i < 4) cycle();
        end
        // Degenerate wrap range: count constant, wrap every enabled cycle, none when disabled.
        do_start(77, 77, 5, 1);
        en_i = 1;
        cycle();
        n_tests++;
        if (count_o !== 8'd77 || wrap_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_equal: count=%0d wrap=%b, need 77 1", count_o, wrap_o);
        end
        en_i = 0;
        cycle();
        n_tests++;
        if (count_o !== 8'd77 || wrap_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_hold: count=%0d wrap=%b, need 77 0", count_o, wrap_o);
        end
        do_start(40, 40, 2, 0);
        n_tests++;
        if (count_o !== 8'd40 || done_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_equal: count=%0d done=%b busy=%b, need 40 1 0",
                     count_o, done_o, busy_o);
        end
    endtask

    task automatic test_cfg_err();
        idle_inputs();
        do_start(20, 5, 1, 0);
        n_tests++;
        if (cfg_err_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || count_o !== 8'd40) begin
            n_fail++;
            $display("FAIL cfg_err: err=%b busy=%b done=%b count=%0d, need 1 0 0 40",
                     cfg_err_o, busy_o, done_o, count_o);
        end
        idle_inputs();
        en_i = 1;
        cycle();
        n_tests++;
        if (cfg_err_o !== 1'b1 || count_o !== 8'd40) begin
            n_fail++;
            $display("FAIL cfg_err_sticky: err=%b count=%0d, need 1 40", cfg_err_o, count_o);
        end
        clear_i = 1;
        cycle();
        clear_i = 0;
        n_tests++;
        if (cfg_err_o !== 1'b0 || count_o !== 8'd0) begin
            n_fail++;
            $display("FAIL cfg_err_clear: err=%b count=%0d, need 0 0", cfg_err_o, count_o);
        end
    endtask

    task automatic test_clear_priority();
        logic en_pat[5] = '{1, 0, 1, 1, 0};
        int   exp_c[5]  = '{2, 2, 4, 6, 6};
        idle_inputs();
        en_i = 1;
        do_start(0, 20, 2, 0);
        cycle(); cycle(); cycle();
        n_tests++;
        if (count_o !== 8'd6) begin
            n_fail++;
            $display("FAIL run_to_6: count=%0d, need 6", count_o);
        end
        clear_i = 1; start_i = 1; start_val_i = 8'd9; end_val_i = 8'd30; step_i = 4'd1;
        cycle();
        clear_i = 0; start_i = 0;
        n_tests++;
        if (count_o !== 8'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_over_start: count=%0d busy=%b, need 0 0", count_o, busy_o);
        end
        do_start(0, 20, 2, 0);
        for (int i = 0; i < 5; i++) begin
            en_i = en_pat[i];
            cycle();
            n_tests++;
            if (count_o !== Bits'(exp_c[i]) || wrap_o !== 1'b0) begin
                n_fail++;
                $display("FAIL en_toggle[%0d]: count=%0d wrap=%b, need %0d 0",
                         i, count_o, wrap_o, exp_c[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        idle_inputs();
        en_i = 1;
        do_start(3, 50, 3, 0);
        cycle(); cycle();
        n_tests++;
        if (count_o !== 8'd9) begin
            n_fail++;
            $display("FAIL pre_reset: count=%0d, need 9", count_o);
        end
        #2 arst_ni = 0;
        model_reset();
        #1;
        n_tests++;
        if (count_o !== 8'd0 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: count=%0d busy=%b, need 0 0", count_o, busy_o);
        end
        #1 arst_ni = 1;
        cycle(); cycle();
        n_tests++;
        if (count_o !== 8'd0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_en: count=%0d busy=%b, need 0 0", count_o, busy_o);
        end
    endtask

    task automatic test_step_zero();
        int exp_c[3] = '{0, 1, 2};
        idle_inputs();
        en_i = 1;
        do_start(0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (count_o !== Bits'(exp_c[i]) || done_o !== (i == 2)) begin
                n_fail++;
                $display("FAIL step_zero[%0d]: count=%0d done=%b, need %0d %b",
                         i, count_o, done_o, exp_c[i], i == 2);
            end
            if (i < 2) cycle();
        end
    endtask

    task automatic test_random();
        int s, w;
        for (int i = 0; i < 3000; i++) begin
            clear_i = ($urandom_range(0, 99) < 2);
            start_i = ($urandom_range(0, 99) < 6);
            en_i    = ($urandom_range(0, 99) < 75);
            mode_i  = 1'($urandom);
            step_i  = StepBits'($urandom);
            s = $urandom_range(0, 255);
            w = $urandom_range(0, 40);
            start_val_i = Bits'(s);
            if ($urandom_range(0, 9) == 0) end_val_i = Bits'($urandom);
            else end_val_i = Bits'((s + w > 255) ? 255 : s + w);
            cycle();
            n_tests++;
            if (count_o !== Bits'(m_count) || busy_o !== (m_state == 1) || done_o !== (m_state == 2)
                || wrap_o !== 1'(m_wrap) || cfg_err_o !== 1'(m_err)) begin
                n_fail++;
                $display("FAIL random[%0d]: count=%0d busy=%b done=%b wrap=%b err=%b, need %0d %b %b %0d %0d",
                         i, count_o, busy_o, done_o, wrap_o, cfg_err_o,
                         m_count, m_state == 1, m_state == 2, m_wrap, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stop_seq();
        test_wrap();
        test_cfg_err();
        test_clear_priority();
        test_async_reset();
        test_step_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
